// File: rtl/rasterizer_pkg.sv
// rasterizer_pkg: shared word geometry and fetch-state encoding for the primitive fetch engine.
`default_nettype none

package rasterizer_pkg;

  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_REQ  = 3'd1,
    HDR_WAIT = 3'd2,
    FETCH    = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/rasterizer_prim_fetch_if.sv
// rasterizer_prim_fetch_if: pipelined Avalon-MM read bus between the fetch engine and the interconnect.
`default_nettype none

interface rasterizer_prim_fetch_if #(
  parameter int ADDR_W = 26
);

  logic [ADDR_W-1:0] address;
  logic              read;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address, read, byteenable,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, byteenable,
    output readdata, readdatavalid, waitrequest
  );

endinterface

`default_nettype wire

// File: rtl/rasterizer_prim_fifo.sv
// rasterizer_prim_fifo: first-word-fall-through synchronous FIFO with occupancy count.
`default_nettype none

module rasterizer_prim_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/rasterizer_prim_fetch.sv
// rasterizer_prim_fetch: reads a primitive-count header, then fetches and assembles primitives into a FIFO.
// Optional stall counter port enabled by defining RASTERIZER_FETCH_PERF_EN.
`default_nettype none

module rasterizer_prim_fetch
  import rasterizer_pkg::*;
#(
  parameter int ADDR_W          = 26,
  parameter int WORDS_PER_PRIM  = 15,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  rasterizer_prim_fetch_if.master          master,
  input  logic                             fetch_enable,
  input  logic [ADDR_W-1:0]                vertex_buffer_base,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [WORD_W*WORDS_PER_PRIM-1:0] prim_out,
  output logic                             done_out,
  output logic [31:0]                      prim_total
`ifdef RASTERIZER_FETCH_PERF_EN
  ,
  output logic [31:0]                      perf_stall_cycles
`endif
);

  localparam int PRIM_W = WORD_W * WORDS_PER_PRIM;
  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int IDX_W  = $clog2(WORDS_PER_PRIM + 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS_PER_PRIM - 1);

  fetch_state_t r_state, w_state_next;

  logic [ADDR_W-1:0]      r_addr;
  logic [31:0]            r_total;
  logic [31:0]            r_cur_prim;
  logic [31:0]            r_outstanding;
  logic [31:0]            r_reserved;
  logic [IDX_W-1:0]       r_req_word;
  logic [IDX_W-1:0]       r_idx;
  logic [PRIM_W-1:0]      r_asm;
  logic [PRIM_W-1:0]      w_asm_next;
  logic                   w_first_word, w_slot_ok, w_credit_ok, w_issue;
  logic                   w_accept, w_req_acc, w_last_req, w_rsp, w_push, w_pop;
  logic                   w_start;
  logic                   w_empty, w_full;
  logic [FIFO_DEPTH_LOG2:0] w_count;

  assign w_start      = (r_state == IDLE) && fetch_enable;
  assign w_first_word = (r_req_word == '0);
  assign w_slot_ok    = r_outstanding < 32'(MAX_OUTSTANDING);
  // Credits cover both primitives sitting in the FIFO and those still being assembled.
  assign w_credit_ok  = !w_full && ((32'(w_count) + r_reserved) < 32'(DEPTH));
  assign w_issue      = (r_state == FETCH) && w_slot_ok && (w_credit_ok || !w_first_word);
  assign w_accept     = master.read && !master.waitrequest;
  assign w_req_acc    = w_accept && (r_state == FETCH);
  assign w_last_req   = (r_cur_prim == r_total - 32'd1) && (r_req_word == LAST_WORD);
  assign w_rsp        = master.readdatavalid && ((r_state == FETCH) || (r_state == DRAIN));
  assign w_push       = w_rsp && (r_idx == LAST_WORD);
  assign w_pop        = out_valid && out_ready;

  assign master.address    = r_addr;
  assign master.byteenable = 4'b1111;
  assign out_valid         = !w_empty;
  assign done_out          = (r_state == DONE);
  assign prim_total        = r_total;

  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[r_idx*WORD_W +: WORD_W] = master.readdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    master.read  = 1'b0;
    unique case (r_state)
      IDLE:     if (fetch_enable) w_state_next = HDR_REQ;
      HDR_REQ: begin
        master.read = 1'b1;
        if (!master.waitrequest) w_state_next = HDR_WAIT;
      end
      HDR_WAIT: if (master.readdatavalid)
                  w_state_next = (master.readdata == 32'd0) ? DONE : FETCH;
      FETCH: begin
        master.read = w_issue;
        if (w_accept && w_last_req) w_state_next = DRAIN;
      end
      DRAIN:    if (r_outstanding == '0 && r_reserved == '0 && w_empty) w_state_next = DONE;
      DONE:     if (!fetch_enable) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr        <= '0;
      r_total       <= '0;
      r_cur_prim    <= '0;
      r_outstanding <= '0;
      r_reserved    <= '0;
      r_req_word    <= '0;
      r_idx         <= '0;
      r_asm         <= '0;
    end else begin
      if (w_start) begin
        r_addr        <= vertex_buffer_base;
        r_cur_prim    <= '0;
        r_outstanding <= '0;
        r_reserved    <= '0;
        r_req_word    <= '0;
        r_idx         <= '0;
      end
      if (r_state == HDR_WAIT && master.readdatavalid) begin
        r_total <= master.readdata;
        r_addr  <= r_addr + ADDR_W'(WORD_BYTES);
      end
      if (w_req_acc) begin
        r_addr <= r_addr + ADDR_W'(WORD_BYTES);
        if (r_req_word == LAST_WORD) begin
          r_req_word <= '0;
          r_cur_prim <= r_cur_prim + 32'd1;
        end else begin
          r_req_word <= r_req_word + 1'b1;
        end
      end
      if (w_rsp) begin
        r_asm <= w_asm_next;
        r_idx <= (r_idx == LAST_WORD) ? '0 : r_idx + 1'b1;
      end
      case ({w_req_acc, w_rsp})
        2'b10:   r_outstanding <= r_outstanding + 32'd1;
        2'b01:   r_outstanding <= r_outstanding - 32'd1;
        default: r_outstanding <= r_outstanding;
      endcase
      case ({w_req_acc && w_first_word, w_push})
        2'b10:   r_reserved <= r_reserved + 32'd1;
        2'b01:   r_reserved <= r_reserved - 32'd1;
        default: r_reserved <= r_reserved;
      endcase
    end
  end

  rasterizer_prim_fifo #(
    .WIDTH      (PRIM_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .din   (w_asm_next),
    .pop   (w_pop),
    .dout  (prim_out),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

`ifdef RASTERIZER_FETCH_PERF_EN
  logic [31:0] r_perf;
  logic        w_credit_block;
  logic        w_stall;

  assign w_credit_block    = (r_state == FETCH) && w_slot_ok && w_first_word && !w_credit_ok;
  assign w_stall           = (master.read && master.waitrequest) || w_credit_block;
  assign perf_stall_cycles = r_perf;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         r_perf <= '0;
    else if (w_start)                  r_perf <= '0;
    else if (w_stall && r_perf != '1)  r_perf <= r_perf + 32'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rasterizer_prim_fetch.sv
// tb_rasterizer_prim_fetch: randomized Avalon slave + reference model of the primitive stream.
`default_nettype none

module tb_rasterizer_prim_fetch;
  localparam int ADDR_W = 26;
  localparam int WPP    = 15;
  localparam int FDL2   = 4;
  localparam int MAXO   = 8;

  logic clock = 1'b0;
  logic reset;
  logic fetch_enable;
  logic [ADDR_W-1:0] base;
  logic out_ready;
  logic out_valid;
  logic [32*WPP-1:0] prim_out;
  logic done_out;
  logic [31:0] prim_total;
`ifdef RASTERIZER_FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
`endif

  rasterizer_prim_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  rasterizer_prim_fetch #(
    .ADDR_W(ADDR_W), .WORDS_PER_PRIM(WPP), .FIFO_DEPTH_LOG2(FDL2), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clock(clock), .reset(reset), .master(bus.master),
    .fetch_enable(fetch_enable), .vertex_buffer_base(base), .out_ready(out_ready),
    .out_valid(out_valid), .prim_out(prim_out), .done_out(done_out), .prim_total(prim_total)
`ifdef RASTERIZER_FETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {logic [31:0] data; int due;} rsp_t;
  rsp_t               rsp_q[$];
  logic [ADDR_W-1:0]  acc_q[$];
  logic [32*WPP-1:0]  got_q[$];
  logic [ADDR_W-1:0]  cur_base;
  int hdr_val, lat = 1, wait_pct = 0, rdy_pct = 100;
  int cyc = 0, n_acc = 0, n_rsp = 0, max_inflight = 0, last_rsp_cyc = 0;
  int stab_err = 0, hold_err = 0, early_done = 0;
  bit ov_seen = 0, pass_active = 0, prev_stall = 0, prev_hold = 0;
  logic [ADDR_W-1:0] prev_addr;
  logic [32*WPP-1:0] prev_prim;
  int n_pass = 0, n_checks = 0, n_fail = 0;

  function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
    if (a == cur_base) return 32'(hdr_val);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Primitive p, word i lives at base + 4 + 4*(p*WPP + i), modulo 2^ADDR_W.
  function automatic logic [511:0] exp_prim(input int p);
    logic [511:0] v = '0;
    for (int i = 0; i < WPP; i++)
      v[32*i +: 32] = word_at(cur_base + ADDR_W'(4 * (1 + p*WPP + i)));
    return v;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave response + randomized stall drive.
  always @(negedge clock) begin
    bus.readdatavalid = 1'b0;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      bus.readdatavalid = 1'b1;
      bus.readdata      = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    bus.waitrequest = ($urandom_range(99) < wait_pct);
    out_ready       = ($urandom_range(99) < rdy_pct);
  end

  // Bus and output monitor.
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      prev_stall = 0;
      prev_hold  = 0;
    end else begin
      if (bus.readdatavalid) begin
        n_rsp++;
        last_rsp_cyc = cyc;
      end
      if (prev_stall && !(bus.read && bus.address == prev_addr)) stab_err++;
      prev_stall = bus.read && bus.waitrequest;
      prev_addr  = bus.address;
      if (bus.read && !bus.waitrequest) begin
        n_acc++;
        acc_q.push_back(bus.address);
        rsp_q.push_back('{word_at(bus.address), cyc + lat});
      end
      if (n_acc - n_rsp > max_inflight) max_inflight = n_acc - n_rsp;
      if (prev_hold && (!out_valid || prim_out !== prev_prim)) hold_err++;
      prev_hold = out_valid && !out_ready;
      prev_prim = prim_out;
      if (out_valid) ov_seen = 1;
      if (out_valid && out_ready) got_q.push_back(prim_out);
      if (done_out && pass_active && got_q.size() < hdr_val) early_done++;
    end
  end

  task automatic start_pass(input logic [ADDR_W-1:0] b, input int hdr, input int l,
                            input int wp, input int rp);
    @(negedge clock);
    cur_base = b; base = b; hdr_val = hdr; lat = l; wait_pct = wp; rdy_pct = rp;
    acc_q.delete(); got_q.delete();
    n_acc = 0; n_rsp = 0; max_inflight = 0; ov_seen = 0;
    pass_active  = 1;
    fetch_enable = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done_out && k < budget) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_done_timeout"}, done_out, 1'b1);
  endtask

  task automatic check_pass(input string tag);
    int aerr = 0;
    check({tag, "_nreads"}, n_acc, 1 + hdr_val * WPP);
    for (int i = 0; i < acc_q.size(); i++)
      if (acc_q[i] !== cur_base + ADDR_W'(4 * i)) aerr++;
    check({tag, "_addr_seq_errs"}, aerr, 0);
    check({tag, "_nprims"}, got_q.size(), hdr_val);
    for (int p = 0; p < got_q.size() && p < hdr_val; p++)
      check($sformatf("%s_prim%0d", tag, p), got_q[p], exp_prim(p));
    check({tag, "_prim_total"}, prim_total, hdr_val);
  endtask

  task automatic end_pass(input string tag);
    pass_active  = 0;
    fetch_enable = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check({tag, "_done_clear"}, done_out, 1'b0);
  endtask

  initial begin
    int k;
    reset = 1'b1; fetch_enable = 1'b0; base = '0;
    repeat (3) @(negedge clock);
    check("rst_read", bus.read, 1'b0);
    check("rst_addr", bus.address, '0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_done", done_out, 1'b0);
    check("rst_total", prim_total, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Empty vertex buffer.
    start_pass(26'h100, 0, 1, 0, 100);
    wait_done("hdr0", 200);
    check("hdr0_done_latency", (cyc - last_rsp_cyc) <= 2, 1'b1);
    check_pass("hdr0");
    check("hdr0_no_valid", ov_seen, 1'b0);
    end_pass("hdr0");

    // Three primitives, zero-wait slave.
    start_pass(26'h2000, 3, 1, 0, 100);
    wait_done("hdr3", 2000);
    check_pass("hdr3");
    check("hdr3_early_done", early_done, 0);
    end_pass("hdr3");

    // Random stalls, back-pressure, address wrap at the top of the space.
    start_pass(26'h3FF_FFF0, 6, 3, 50, 60);
    wait_done("stall", 5000);
    check_pass("stall");
    check("stall_addr_stable", stab_err, 0);
    check("stall_prim_hold", hold_err, 0);
    end_pass("stall");

    // FIFO-full back-pressure: only 16 primitives may be requested.
    start_pass(26'h4_0000, 40, 1, 0, 0);
    repeat (600) @(negedge clock);
    check("bp_reads_capped", n_acc, 1 + 16 * WPP);
    check("bp_read_idle", bus.read, 1'b0);
    check("bp_none_popped", got_q.size(), 0);
    rdy_pct = 100;
    wait_done("bp", 5000);
    check_pass("bp");
    check("bp_early_done", early_done, 0);
    end_pass("bp");

    // Long latency: in-flight reads limited by MAX_OUTSTANDING.
    start_pass(26'h8_0000, 4, 10, 0, 100);
    wait_done("lat10", 5000);
    check_pass("lat10");
    check("lat10_max_outstanding", max_inflight, MAXO);
    end_pass("lat10");

    // Reset in the middle of FETCH with responses pending.
    start_pass(26'hC_0000, 10, 10, 0, 100);
    k = 0;
    while (!(n_acc >= 25 && rsp_q.size() >= 3) && k < 2000) begin
      @(negedge clock);
      k++;
    end
    check("rst_mid_reached", (n_acc >= 25 && rsp_q.size() >= 3), 1'b1);
    pass_active = 0;
    reset = 1'b1;
    fetch_enable = 1'b0;
    #1;
    check("rst_mid_read", bus.read, 1'b0);
    check("rst_mid_addr", bus.address, '0);
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_total", prim_total, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    k = 0;
    while (rsp_q.size() > 0 && k < 200) begin
      @(negedge clock);
      k++;
    end
    repeat (3) @(negedge clock);
    check("rst_late_ignored_valid", out_valid, 1'b0);
    check("rst_late_ignored_done", done_out, 1'b0);
    start_pass(26'h10_0000, 2, 2, 30, 100);
    wait_done("post_rst", 3000);
    check_pass("post_rst");
    end_pass("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
